multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
- Multi-cycle control unit for the next-generation MIPS core. Replaces the single-cycle combinational controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with instruction and data memories that may take several cycles; a per-access watchdog traps hung memories.
- Drives the existing datapath muxes, with PC/IR/register/memory write enables asserted only in the proper state. Also counts retired instructions.

Parameters:
- ALU_OP_W, 4, width of alu_op. Encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 XOR.
- MEM_TIMEOUT, 16, max wait cycles per memory access before FAULT; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (valid with dmem_req)
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  0 pc+4, 1 branch target, 2 jump target, 3 rs
- reg_write  out  1  register file write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- reg_src  out  2  0 alu, 1 mem, 2 pc+4 (link), 3 ext imm
- alu_src  out  1  0 rt data, 1 extended imm
- ext_op  out  2  0 zero-extend, 1 sign-extend, 2 lui (imm<<16)
- alu_op  out  ALU_OP_W  ALU operation
- fault  out  1  sticky trap flag
- state  out  3  current state for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- Reset (async, any time, including mid-access): state=FETCH, wait counter=0, retired=0, fault=0.
- All outputs are combinational from state, opcode, func and zero. Every enable/request not listed for a state is 0, and selects are 0.
- Supported instructions:
  - R-type (opcode 000000): addu 100001, subu 100011, and 100100, or 100101, xor 100110, slt 101010, sll 000000, srl 000010, jr 001000.
  - I/J-type: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_write=1, clear wait counter, go to DECODE.
  - Else increment wait counter. If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT, go to FAULT.
- DECODE: one cycle. Unsupported opcode/func goes to FAULT; otherwise go to EXEC.
- EXEC: drive alu_op/alu_src/ext_op for the instruction. Then:
  - beq: pc_write=1, pc_src=1 if zero else 0; go to FETCH.
  - j: pc_write=1, pc_src=2; go to FETCH.
  - jal: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, reg_src=2; go to FETCH.
  - jr: pc_write=1, pc_src=3; go to FETCH.
  - lw/sw: alu_op=ADD, alu_src=1, ext_op=1; go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1, dmem_we=1 for sw; hold alu controls.
  - On dmem_ready: sw does pc_write=1, pc_src=0 and goes to FETCH; lw goes to WB.
  - Watchdog behaves exactly as in FETCH.
- WB:
  - reg_write=1, pc_write=1, pc_src=0; go to FETCH.
  - R-type: reg_dst=1, reg_src=0.
  - addiu/ori: reg_dst=0, reg_src=0.
  - lui: reg_dst=0, reg_src=3, ext_op=2.
  - lw: reg_dst=0, reg_src=1.
  - Controls are held stable for the whole cycle.
- retired increments by 1 on every clock edge where pc_write=1, and wraps modulo 2^CNT_W.
- FAULT: all enables 0, fault=1. The unit stays in FAULT until rst.
- Ready asserted while the corresponding req=0 is ignored.
- Cycle counts with zero-wait memories: R/I-type 4, lw 5, sw 4, beq/j/jal/jr 3.

Test Plan:
- Reset mid-MEM (rst pulsed while dmem_req=1) -> immediate state=0, fault=0, retired=0, dmem_req=0 without waiting for a clock edge.
- addu with imem_ready=1 -> states 0,1,2,4,0; in WB reg_write=1, reg_dst=1, pc_write=1; retired 0->1 after the 4th edge.
- lw with imem_ready held low for 3 cycles and dmem_ready low for 2 cycles -> 5+3+2=10 cycles; ir_write exactly one pulse; reg_src=1 in WB.
- beq with zero=1, then beq with zero=0 -> EXEC pc_src=1, then 0; no reg_write in either; each takes 3 cycles.
- jal -> EXEC reg_write=1, reg_dst=2, reg_src=2, pc_src=2 in the same cycle.
- MEM_TIMEOUT=4, imem_ready never asserted -> FAULT after 4 wait cycles; fault stays 1 for 100 cycles; undefined opcode 111111 -> FAULT from DECODE.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, per-access watchdog, sticky fault and retired counter.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   opcode, func, zero        IR fields and ALU zero flag
//   imem_ready, dmem_ready    memory completion strobes
//   imem_req, dmem_req,
//   dmem_we                   memory requests
//   ir_write, pc_write,
//   reg_write                 datapath write enables
//   pc_src, reg_dst, reg_src,
//   alu_src, ext_op, alu_op   datapath selects
//   fault, state, retired     trap flag, debug state, retired count
module multicycle_cu #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_src,
  output logic                alu_src,
  output logic [1:0]          ext_op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                fault,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(7);

  // Counter only needs to reach MEM_TIMEOUT; keep one bit when disabled.
  localparam int WAIT_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                time_out;

  logic is_r;
  logic i_addu, i_subu, i_and, i_or, i_xor;
  logic i_slt, i_sll, i_srl, i_jr;
  logic i_addiu, i_ori, i_lui, i_lw, i_sw;
  logic i_beq, i_j, i_jal;
  logic r_alu, legal;

  assign is_r    = (opcode == 6'b000000);
  assign i_addu  = is_r && (func == 6'b100001);
  assign i_subu  = is_r && (func == 6'b100011);
  assign i_and   = is_r && (func == 6'b100100);
  assign i_or    = is_r && (func == 6'b100101);
  assign i_xor   = is_r && (func == 6'b100110);
  assign i_slt   = is_r && (func == 6'b101010);
  assign i_sll   = is_r && (func == 6'b000000);
  assign i_srl   = is_r && (func == 6'b000010);
  assign i_jr    = is_r && (func == 6'b001000);
  assign i_addiu = (opcode == 6'b001001);
  assign i_ori   = (opcode == 6'b001101);
  assign i_lui   = (opcode == 6'b001111);
  assign i_lw    = (opcode == 6'b100011);
  assign i_sw    = (opcode == 6'b101011);
  assign i_beq   = (opcode == 6'b000100);
  assign i_j     = (opcode == 6'b000010);
  assign i_jal   = (opcode == 6'b000011);

  assign r_alu = i_addu | i_subu | i_and | i_or
               | i_xor | i_slt | i_sll | i_srl;
  assign legal = r_alu | i_jr | i_addiu | i_ori
               | i_lui | i_lw | i_sw | i_beq
               | i_j | i_jal;

  assign wait_inc = wait_q + WAIT_W'(1);
  assign time_out = (MEM_TIMEOUT != 0) && (wait_inc == WAIT_LIM);

  logic [ALU_OP_W-1:0] alu_op_i;
  logic                alu_src_i;
  logic [1:0]          ext_op_i;

  always_comb begin
    alu_op_i  = ALU_ADD;
    alu_src_i = 1'b0;
    ext_op_i  = 2'd0;
    unique case (1'b1)
      i_subu: alu_op_i = ALU_SUB;
      i_and:  alu_op_i = ALU_AND;
      i_or:   alu_op_i = ALU_OR;
      i_xor:  alu_op_i = ALU_XOR;
      i_slt:  alu_op_i = ALU_SLT;
      i_sll:  alu_op_i = ALU_SLL;
      i_srl:  alu_op_i = ALU_SRL;
      i_beq:  alu_op_i = ALU_SUB;
      i_addiu, i_lw, i_sw: begin
        alu_src_i = 1'b1;
        ext_op_i  = 2'd1;
      end
      i_ori: begin
        alu_op_i  = ALU_OR;
        alu_src_i = 1'b1;
      end
      i_lui: begin
        alu_src_i = 1'b1;
        ext_op_i  = 2'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    reg_src   = 2'd0;
    alu_src   = 1'b0;
    ext_op    = 2'd0;
    alu_op    = ALU_ADD;
    fault     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (time_out) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        alu_op  = alu_op_i;
        alu_src = alu_src_i;
        ext_op  = ext_op_i;
        state_d = S_WB;
        if (i_beq) begin
          pc_write = 1'b1;
          pc_src   = zero ? 2'd1 : 2'd0;
          state_d  = S_FETCH;
        end else if (i_j) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = S_FETCH;
        end else if (i_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          reg_src   = 2'd2;
          state_d   = S_FETCH;
        end else if (i_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          state_d  = S_FETCH;
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        alu_op   = alu_op_i;
        alu_src  = alu_src_i;
        ext_op   = ext_op_i;
        dmem_req = 1'b1;
        dmem_we  = i_sw;
        if (dmem_ready) begin
          if (i_sw) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_inc;
          if (time_out) state_d = S_FAULT;
        end
      end
      S_WB: begin
        alu_op    = alu_op_i;
        alu_src   = alu_src_i;
        ext_op    = ext_op_i;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        if (is_r)  reg_dst = 2'd1;
        if (i_lui) reg_src = 2'd3;
        if (i_lw)  reg_src = 2'd1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase
  end

  assign retired_d = pc_write ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: random instruction stream with random
// memory latency, plus directed reset, watchdog and illegal-decode cases.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] pc_src, reg_dst, reg_src, ext_op;
  logic       alu_src, fault;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic [3:0] retired;

  multicycle_cu #(
    .ALU_OP_W(4), .MEM_TIMEOUT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .reg_src(reg_src), .alu_src(alu_src),
    .ext_op(ext_op), .alu_op(alu_op),
    .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   st, pcs, rw, rd, rs;
    int   cyc, rwn;
    bit   sw;
    bit   chk_alu;
    int   alu, asrc;
    bit   chk_ext;
    int   ext;
    int   ret;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_issued = 0;
  bit   mon_en = 1'b0;
  int   cyc_n = 0, ir_n = 0, rw_n = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0..7 R-type ALU ops, 8 jr, 9 addiu, 10 ori, 11 lui,
  // 12 lw, 13 sw, 14 beq, 15 j, 16 jal
  function automatic void enc(input int idx,
                              output logic [5:0] op,
                              output logic [5:0] fn);
    logic [5:0] rf [9];
    logic [5:0] io [17];
    rf = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
           6'h2a, 6'h00, 6'h02, 6'h08};
    io = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
           6'h00, 6'h00, 6'h00, 6'h09, 6'h0d, 6'h0f,
           6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    op = io[idx];
    fn = (idx <= 8) ? rf[idx] : 6'($urandom);
  endfunction

  // Expected behaviour of the retiring cycle, from the instruction's class.
  function automatic exp_t model(input int idx, input bit z,
                                 input int iw, input int dw);
    exp_t e;
    int   r_alu [8];
    r_alu = '{0, 1, 2, 3, 7, 4, 5, 6};
    e = '{st: 4, pcs: 0, rw: 1, rd: 0, rs: 0, cyc: 4 + iw,
          rwn: 1, sw: 0, chk_alu: 0, alu: 0, asrc: 0,
          chk_ext: 0, ext: 0, ret: 0};
    if (idx <= 7) begin
      e.rd = 1; e.chk_alu = 1; e.alu = r_alu[idx];
    end else if (idx == 9 || idx == 10) begin
      e.chk_alu = 1; e.alu = (idx == 10) ? 3 : 0; e.asrc = 1;
      e.chk_ext = 1; e.ext = (idx == 9) ? 1 : 0;
    end else if (idx == 11) begin
      e.rs = 3; e.chk_ext = 1; e.ext = 2;
    end else if (idx == 12 || idx == 13) begin
      e.chk_alu = 1; e.alu = 0; e.asrc = 1;
      e.chk_ext = 1; e.ext = 1;
      e.cyc = 5 + iw + dw;
      e.rs = 1;
      if (idx == 13) begin
        e.st = 3; e.rw = 0; e.rwn = 0; e.rs = 0;
        e.sw = 1; e.cyc = 4 + iw + dw;
      end
    end else begin
      e.st = 2; e.cyc = 3 + iw; e.rw = 0; e.rwn = 0;
      case (idx)
        8:  e.pcs = 3;
        14: e.pcs = z ? 1 : 0;
        15: e.pcs = 2;
        default: begin
          e.pcs = 2; e.rw = 1; e.rwn = 1; e.rd = 2; e.rs = 2;
        end
      endcase
    end
    return e;
  endfunction

  task automatic issue(input int idx, input bit z,
                       input int iw, input int dw);
    logic [5:0] op, fn;
    exp_t       e;
    enc(idx, op, fn);
    e = model(idx, z, iw, dw);
    e.ret = n_issued % 16;
    n_issued++;
    q.push_back(e);
    opcode = op;
    func   = fn;
    zero   = z;
    for (int k = 0; k <= iw; k++) begin
      imem_ready = (k == iw);
      dmem_ready = 1'($urandom_range(1));
      step();
    end
    imem_ready = 1'($urandom_range(1));
    step();
    dmem_ready = 1'($urandom_range(1));
    step();
    if (idx == 12 || idx == 13) begin
      for (int k = 0; k <= dw; k++) begin
        dmem_ready = (k == dw);
        imem_ready = 1'($urandom_range(1));
        step();
      end
    end
    if (idx <= 7 || (idx >= 9 && idx <= 12)) begin
      imem_ready = 1'($urandom_range(1));
      dmem_ready = 1'($urandom_range(1));
      step();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      cyc_n++;
      if (ir_write)  ir_n++;
      if (reg_write) rw_n++;
      if (dmem_req && q.size() > 0)
        chk("dmem_we", dmem_we, q[0].sw);
      if (pc_write) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = q.pop_front();
          chk("retire_state", state, e.st);
          chk("pc_src", pc_src, e.pcs);
          chk("reg_write", reg_write, e.rw);
          chk("reg_dst", reg_dst, e.rd);
          chk("reg_src", reg_src, e.rs);
          chk("cycles", cyc_n, e.cyc);
          chk("ir_write_pulses", ir_n, 1);
          chk("reg_write_cycles", rw_n, e.rwn);
          chk("retired", retired, e.ret);
          if (e.chk_alu) begin
            chk("alu_op", alu_op, e.alu);
            chk("alu_src", alu_src, e.asrc);
          end
          if (e.chk_ext) chk("ext_op", ext_op, e.ext);
        end
        cyc_n = 0;
        ir_n  = 0;
        rw_n  = 0;
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ret_hold;
    logic [5:0] bad_op [2];
    logic [5:0] bad_fn [2];
    rst = 1'b1;
    opcode = '0; func = '0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    chk("fetch_req", imem_req, 1);
    mon_en = 1'b1;

    issue(0, 1'b0, 0, 0);
    issue(12, 1'b0, 3, 2);
    issue(14, 1'b1, 0, 0);
    issue(14, 1'b0, 0, 0);
    issue(16, 1'b0, 0, 0);
    issue(13, 1'b0, 3, 3);
    for (int n = 0; n < 40; n++)
      issue($urandom_range(16), 1'($urandom_range(1)),
            $urandom_range(3), $urandom_range(3));
    chk("queue_empty", q.size(), 0);
    chk("retired_total", retired, n_issued % 16);
    mon_en = 1'b0;

    // Asynchronous reset while a load is waiting on data memory.
    opcode = 6'h23; func = '0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    step();
    imem_ready = 1'b0;
    step();
    step();
    chk("mem_req_before_rst", {state, dmem_req}, {3'd3, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_req", dmem_req, 0);
    chk("async_rst_fault", fault, 0);
    chk("async_rst_retired", retired, 0);
    step();
    rst = 1'b0;

    // Instruction memory never answers: watchdog trips on the 4th wait.
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("watchdog_state", state, (k < 4) ? 0 : 5);
    end
    ret_hold = retired;
    for (int k = 0; k < 100; k++) begin
      imem_ready = 1'($urandom_range(1));
      dmem_ready = 1'($urandom_range(1));
      step();
      chk("fault_hold",
          {fault, state, imem_req, dmem_req, pc_write,
           reg_write, ir_write, dmem_we},
          {1'b1, 3'd5, 6'd0});
    end
    chk("fault_retired", retired, ret_hold);

    // Illegal opcode and unsupported R-type func both trap in DECODE.
    bad_op = '{6'h3f, 6'h00};
    bad_fn = '{6'h00, 6'h20};
    for (int b = 0; b < 2; b++) begin
      pulse_reset();
      chk("clear_fault", fault, 0);
      opcode = bad_op[b];
      func   = bad_fn[b];
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      chk("bad_decode_state", state, 1);
      step();
      chk("bad_trap_state", state, 5);
      chk("bad_trap_fault", fault, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
